sys_text_overlay: RTL and testbench

Parametrised character-cell text overlay for the system/debug screen. Replaces the fixed single-glyph analyzer with a writable COLS x ROWS character buffer, per-cell colour/blink attributes, row scrolling, a hardware clear sequencer and an optional 90-degree rotated scan. Input is the raw video h/v counters. Output is a fixed-latency pixel stream for mixing over game video.

---
 rtl/sys_text_pkg.sv | 26 ++
 rtl/sys_text_if.sv | 19 +
 rtl/sys_text_font_rom.sv | 87 ++++++++
 rtl/sys_text_overlay.sv | 204 ++++++++++++++++++++
 tb/tb_sys_text_overlay.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_text_pkg.sv
// Shared constants, cell payload and clear-FSM encoding for the text overlay.
package sys_text_pkg;

    localparam int unsigned GLYPH_W    = 8;
    localparam int unsigned GLYPH_H    = 16;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;

    localparam int unsigned ATTR_BLINK = 3;
    localparam int unsigned ATTR_R     = 2;
    localparam int unsigned ATTR_G     = 1;
    localparam int unsigned ATTR_B     = 0;

    // One character cell as stored in the buffer: {attr, ascii}
    typedef struct packed {
        logic [3:0] attr;
        logic [7:0] ascii;
    } cell_t;

    localparam cell_t CELL_BLANK = '{attr: 4'h0, ascii: CHAR_SPACE};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sys_text_if.sv
// Buffer write / clear bus of the text overlay.
interface sys_text_if #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 8
);
    import sys_text_pkg::*;

    localparam int unsigned ADDR_W = $clog2(COLS * ROWS);

    logic              i_wr;
    logic [ADDR_W-1:0] i_wr_addr;
    cell_t             i_wr_data;
    logic              i_clear;
    logic              o_busy;

    modport master (output i_wr, i_wr_addr, i_wr_data, i_clear, input o_busy);
    modport slave  (input  i_wr, i_wr_addr, i_wr_data, i_clear, output o_busy);

endinterface

// File: rtl/sys_text_font_rom.sv
// 8x16 font: 5x7 base glyphs (digits, letters, a few symbols) placed at
// columns 1..5 and doubled vertically onto rows 1..14. Lowercase maps to
// uppercase; all other codes are blank. Registered output, latency 1.
module sys_text_font_rom
    import sys_text_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] i_ascii,
    input  logic [3:0] i_gy,
    input  logic [2:0] i_gx,
    output logic       o_pixel
);

    function automatic logic [34:0] glyph_5x7(input logic [7:0] c);
        logic [34:0] g;
        g = 35'd0;
        case (c)
            8'h30: g = 35'b01110_10001_10011_10101_11001_10001_01110;
            8'h31: g = 35'b00100_01100_00100_00100_00100_00100_01110;
            8'h32: g = 35'b01110_10001_00001_00010_00100_01000_11111;
            8'h33: g = 35'b11111_00010_00100_00010_00001_10001_01110;
            8'h34: g = 35'b00010_00110_01010_10010_11111_00010_00010;
            8'h35: g = 35'b11111_10000_11110_00001_00001_10001_01110;
            8'h36: g = 35'b00110_01000_10000_11110_10001_10001_01110;
            8'h37: g = 35'b11111_00001_00010_00100_01000_01000_01000;
            8'h38: g = 35'b01110_10001_10001_01110_10001_10001_01110;
            8'h39: g = 35'b01110_10001_10001_01111_00001_00010_01100;
            8'h3A: g = 35'b00000_01100_01100_00000_01100_01100_00000;
            8'h2D: g = 35'b00000_00000_00000_11111_00000_00000_00000;
            8'h2E: g = 35'b00000_00000_00000_00000_00000_01100_01100;
            8'h41: g = 35'b01110_10001_10001_11111_10001_10001_10001;
            8'h42: g = 35'b11110_10001_10001_11110_10001_10001_11110;
            8'h43: g = 35'b01110_10001_10000_10000_10000_10001_01110;
            8'h44: g = 35'b11100_10010_10001_10001_10001_10010_11100;
            8'h45: g = 35'b11111_10000_10000_11110_10000_10000_11111;
            8'h46: g = 35'b11111_10000_10000_11110_10000_10000_10000;
            8'h47: g = 35'b01110_10001_10000_10111_10001_10001_01111;
            8'h48: g = 35'b10001_10001_10001_11111_10001_10001_10001;
            8'h49: g = 35'b01110_00100_00100_00100_00100_00100_01110;
            8'h4A: g = 35'b00111_00010_00010_00010_00010_10010_01100;
            8'h4B: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            8'h4C: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            8'h4D: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            8'h4E: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            8'h4F: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            8'h50: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            8'h51: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            8'h52: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            8'h53: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            8'h54: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            8'h55: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            8'h56: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            8'h57: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            8'h58: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            8'h59: g = 35'b10001_10001_10001_01010_00100_00100_00100;
            8'h5A: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            default: g = 35'd0;
        endcase
        return g;
    endfunction

    logic [7:0]  w_char;
    logic [34:0] w_glyph;
    logic [2:0]  w_row;
    logic [2:0]  w_col;
    logic [5:0]  w_idx;
    logic        w_pixel;

    // Glyph bit select; bit 34 is the top-left pixel of the 5x7 base
    always_comb begin
        w_char  = ((i_ascii >= 8'h61) && (i_ascii <= 8'h7A)) ? (i_ascii & 8'hDF) : i_ascii;
        w_glyph = glyph_5x7(w_char);
        w_row   = 3'((i_gy - 4'd1) >> 1);
        w_col   = i_gx - 3'd1;
        w_idx   = 6'd34 - (6'd5 * {3'd0, w_row}) - {3'd0, w_col};
        w_pixel = 1'b0;
        if ((i_gx >= 3'd1) && (i_gx <= 3'd5) && (i_gy >= 4'd1) && (i_gy <= 4'd14)) begin
            w_pixel = w_glyph[w_idx];
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        o_pixel <= w_pixel;
    end

endmodule

// File: rtl/sys_text_overlay.sv
// Character-cell text overlay: COLSxROWS buffer, per-cell colour/blink,
// row scroll, hardware clear sweep, optional rotated scan. Fixed 4-clk latency.
module sys_text_overlay
    import sys_text_pkg::*;
#(
    parameter int unsigned      COLS     = 32,
    parameter int unsigned      ROWS     = 8,
    parameter int unsigned      ORIGIN_H = 16,
    parameter int unsigned      ORIGIN_V = 16,
    parameter int unsigned      ROTATE   = 0,
    parameter int unsigned      CBITS    = 2,
    parameter logic [3*CBITS-1:0] BG     = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              i_h,
    input  logic [11:0]              i_v,
    input  logic                     i_enable,
    input  logic                     i_frame,
    input  logic [$clog2(ROWS)-1:0]  i_scroll,
    sys_text_if.slave                io_bus,
    output logic                     o_active,
    output logic                     o_ce_pixel,
    output logic [CBITS-1:0]         o_r,
    output logic [CBITS-1:0]         o_g,
    output logic [CBITS-1:0]         o_b
);

    localparam int unsigned       COL_W     = $clog2(COLS);
    localparam int unsigned       ROW_W     = $clog2(ROWS);
    localparam int unsigned       ADDR_W    = COL_W + ROW_W;
    localparam int unsigned       CELLS     = COLS * ROWS;
    localparam logic [11:0]       WIN_W     = 12'(COLS * GLYPH_W);
    localparam logic [11:0]       WIN_H     = 12'(ROWS * GLYPH_H);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);

    // ---------------- window test and cell address ----------------
    logic [11:0]       w_a;
    logic [11:0]       w_b;
    logic              w_inside;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_rd_addr;

    // Window coordinates; wrapped subtraction pushes below-origin pixels outside
    always_comb begin
        w_a       = ((ROTATE != 0) ? i_v : i_h) - 12'(ORIGIN_H);
        w_b       = ((ROTATE != 0) ? i_h : i_v) - 12'(ORIGIN_V);
        w_inside  = i_enable && (w_a < WIN_W) && (w_b < WIN_H);
        w_row     = w_b[4 +: ROW_W] + i_scroll;
        w_rd_addr = {w_row, w_a[3 +: COL_W]};
    end

    // ---------------- pipeline registers ----------------
    logic [ADDR_W-1:0] r1_addr;
    logic [2:0]        r1_gx;
    logic [3:0]        r1_gy;
    logic              r1_inside;
    cell_t             r2_cell;
    logic [2:0]        r2_gx;
    logic [3:0]        r2_gy;
    logic              r2_inside;
    logic [3:0]        r3_attr;
    logic              r3_inside;
    logic              w_font_px;
    logic              w_lit;
    logic [5:0]        r_blink_cnt;

    // S1..S3 side-band alignment; reset leaves every stage "outside"
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_addr   <= '0;
            r1_gx     <= '0;
            r1_gy     <= '0;
            r1_inside <= 1'b0;
            r2_gx     <= '0;
            r2_gy     <= '0;
            r2_inside <= 1'b0;
            r3_attr   <= '0;
            r3_inside <= 1'b0;
        end else begin
            r1_addr   <= w_rd_addr;
            r1_gx     <= w_a[2:0];
            r1_gy     <= w_b[3:0];
            r1_inside <= w_inside;
            r2_gx     <= r1_gx;
            r2_gy     <= r1_gy;
            r2_inside <= r1_inside;
            r3_attr   <= r2_cell.attr;
            r3_inside <= r2_inside;
        end
    end

    // ---------------- character buffer ----------------
    cell_t             r_mem [CELLS];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    cell_t             w_wdata;

    // Simple dual-port RAM; same-cell read/write returns old data
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r2_cell <= r_mem[r1_addr];
    end

    sys_text_font_rom u_font (
        .clk     (clk),
        .i_ascii (r2_cell.ascii),
        .i_gy    (r2_gy),
        .i_gx    (r2_gx),
        .o_pixel (w_font_px)
    );

    // ---------------- clear sequencer ----------------
    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    // State register; reset always (re)starts the sweep at address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next state and write-port steering; clear beats a same-cycle write
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_we           = 1'b0;
        w_waddr        = io_bus.i_wr_addr;
        w_wdata        = io_bus.i_wr_data;
        unique case (r_state)
            ST_IDLE: begin
                if (io_bus.i_clear) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end else if (io_bus.i_wr) begin
                    w_we = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_we           = 1'b1;
                w_waddr        = r_clr_addr;
                w_wdata        = CELL_BLANK;
                w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == ADDR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign io_bus.o_busy = (r_state == ST_CLEAR);

    // ---------------- blink and colour ----------------
    // Blink timebase, one step per frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= '0;
        end else if (i_frame) begin
            r_blink_cnt <= r_blink_cnt + 6'd1;
        end
    end

    // Blink cells are hidden during the upper half of the blink period
    always_comb begin
        w_lit = w_font_px && !(r3_attr[ATTR_BLINK] && r_blink_cnt[5]);
    end

    // S4: colour mux into output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            o_active   <= 1'b0;
            o_ce_pixel <= 1'b0;
            o_r        <= '0;
            o_g        <= '0;
            o_b        <= '0;
        end else begin
            o_active   <= r3_inside;
            o_ce_pixel <= r3_inside && w_lit;
            if (!r3_inside) begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end else if (w_lit) begin
                o_r <= {CBITS{r3_attr[ATTR_R]}};
                o_g <= {CBITS{r3_attr[ATTR_G]}};
                o_b <= {CBITS{r3_attr[ATTR_B]}};
            end else begin
                o_r <= BG[2*CBITS +: CBITS];
                o_g <= BG[CBITS +: CBITS];
                o_b <= BG[0 +: CBITS];
            end
        end
    end

endmodule

// File: tb/tb_sys_text_overlay.sv
// Directed bench for sys_text_overlay: one normal and one rotated instance.
module tb_sys_text_overlay;
    import sys_text_pkg::*;

    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 8;
    localparam logic [5:0]  BG   = 6'b01_10_11;

    localparam logic [8:0] PX_OUT   = 9'b0;
    localparam logic [8:0] PX_BG    = {2'b10, BG};
    localparam logic [8:0] PX_WHITE = {2'b11, 6'b11_11_11};
    localparam logic [8:0] PX_RED   = {2'b11, 6'b11_00_00};
    localparam logic [8:0] PX_GREEN = {2'b11, 6'b00_11_00};
    localparam logic [8:0] PX_BLUE  = {2'b11, 6'b00_00_11};

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] h, v;
    logic        en, frame;
    logic [2:0]  scroll;
    logic        o_active0, o_ce0, o_active1, o_ce1;
    logic [1:0]  o_r0, o_g0, o_b0, o_r1, o_g1, o_b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sys_text_if #(.COLS(COLS), .ROWS(ROWS)) bus0 ();
    sys_text_if #(.COLS(COLS), .ROWS(ROWS)) bus1 ();

    sys_text_overlay #(.COLS(COLS), .ROWS(ROWS), .ORIGIN_H(16), .ORIGIN_V(16),
                       .ROTATE(0), .CBITS(2), .BG(BG)) u_dut (
        .clk(clk), .reset(reset), .i_h(h), .i_v(v), .i_enable(en), .i_frame(frame),
        .i_scroll(scroll), .io_bus(bus0), .o_active(o_active0), .o_ce_pixel(o_ce0),
        .o_r(o_r0), .o_g(o_g0), .o_b(o_b0));

    sys_text_overlay #(.COLS(COLS), .ROWS(ROWS), .ORIGIN_H(16), .ORIGIN_V(16),
                       .ROTATE(1), .CBITS(2), .BG(BG)) u_rot (
        .clk(clk), .reset(reset), .i_h(h), .i_v(v), .i_enable(en), .i_frame(frame),
        .i_scroll(scroll), .io_bus(bus1), .o_active(o_active1), .o_ce_pixel(o_ce1),
        .o_r(o_r1), .o_g(o_g1), .o_b(o_b1));

    typedef struct {
        int          phase;
        logic        dut;
        logic [11:0] h;
        logic [11:0] v;
        logic        en;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs[$];

    // 'A' as rendered: byte per glyph row, bit 7 = gx 0
    logic [7:0] a_bmp [16] = '{8'h00, 8'h38, 8'h38, 8'h44, 8'h44, 8'h44, 8'h44, 8'h7C,
                               8'h7C, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h00};

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] px(input logic sel);
        return sel ? {o_active1, o_ce1, o_r1, o_g1, o_b1}
                   : {o_active0, o_ce0, o_r0, o_g0, o_b0};
    endfunction

    task automatic apply_px(input logic [11:0] ph, input logic [11:0] pv, input logic pen);
        h  = ph;
        v  = pv;
        en = pen;
        tick(4);
    endtask

    task automatic wr(input logic sel, input logic [7:0] addr, input logic [11:0] data);
        if (sel) begin
            bus1.i_wr = 1'b1; bus1.i_wr_addr = addr; bus1.i_wr_data = data;
        end else begin
            bus0.i_wr = 1'b1; bus0.i_wr_addr = addr; bus0.i_wr_data = data;
        end
        tick();
        bus0.i_wr = 1'b0;
        bus1.i_wr = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
        end
    endtask

    // Count consecutive busy samples, bounded
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus0.o_busy !== 1'b1) break;
            cnt++;
            tick();
        end
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                apply_px(vecs[i].h, vecs[i].v, vecs[i].en);
                check($sformatf("vec%0d", i), 32'(px(vecs[i].dut)), 32'(vecs[i].exp));
            end
        end
    endtask

    initial begin
        int cnt;
        // phase 0: freshly cleared buffers
        vecs.push_back('{0, 1'b0, 12'd16,  12'd16,  1'b1, PX_BG});
        vecs.push_back('{0, 1'b0, 12'd271, 12'd143, 1'b1, PX_BG});
        vecs.push_back('{0, 1'b0, 12'd15,  12'd16,  1'b1, PX_OUT});
        vecs.push_back('{0, 1'b0, 12'd100, 12'd60,  1'b0, PX_OUT});
        vecs.push_back('{0, 1'b1, 12'd16,  12'd16,  1'b1, PX_BG});
        // phase 1: 'A' white at cell 0 of both instances
        vecs.push_back('{1, 1'b0, 12'd16,  12'd16,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b0, 12'd18,  12'd17,  1'b1, PX_WHITE});
        vecs.push_back('{1, 1'b0, 12'd16,  12'd17,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b0, 12'd20,  12'd23,  1'b1, PX_WHITE});
        vecs.push_back('{1, 1'b0, 12'd22,  12'd17,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b0, 12'd18,  12'd17,  1'b0, PX_OUT});
        vecs.push_back('{1, 1'b0, 12'd15,  12'd17,  1'b1, PX_OUT});
        vecs.push_back('{1, 1'b0, 12'd16,  12'd15,  1'b1, PX_OUT});
        vecs.push_back('{1, 1'b0, 12'd272, 12'd17,  1'b1, PX_OUT});
        vecs.push_back('{1, 1'b0, 12'd271, 12'd17,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b0, 12'd16,  12'd144, 1'b1, PX_OUT});
        vecs.push_back('{1, 1'b0, 12'd16,  12'd143, 1'b1, PX_BG});
        vecs.push_back('{1, 1'b0, 12'd24,  12'd17,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b1, 12'd17,  12'd18,  1'b1, PX_WHITE});
        vecs.push_back('{1, 1'b1, 12'd18,  12'd17,  1'b1, PX_BG});
        vecs.push_back('{1, 1'b1, 12'd15,  12'd18,  1'b1, PX_OUT});
        vecs.push_back('{1, 1'b1, 12'd17,  12'd272, 1'b1, PX_OUT});
        vecs.push_back('{1, 1'b1, 12'd143, 12'd18,  1'b1, PX_BG});

        reset = 1'b1; h = 12'd18; v = 12'd17; en = 1'b1; frame = 1'b0; scroll = '0;
        bus0.i_wr = 1'b0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0; bus0.i_clear = 1'b0;
        bus1.i_wr = 1'b0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0; bus1.i_clear = 1'b0;
        tick(3);
        check("reset_px", 32'(px(1'b0)), 32'(PX_OUT));
        check("reset_busy", 32'(bus0.o_busy), 32'd1);
        reset = 1'b0;
        count_busy(cnt);
        check("busy_len_reset", cnt, 32'd256);
        check("rot_busy_done", 32'(bus1.o_busy), 32'd0);

        run_phase(0);

        wr(1'b0, 8'd0, 12'h741);
        wr(1'b1, 8'd0, 12'h741);
        run_phase(1);

        // full 'A' bitmap at cell 0
        for (int gy = 0; gy < 16; gy++) begin
            for (int gx = 0; gx < 8; gx++) begin
                logic [7:0] row;
                row = a_bmp[gy];
                apply_px(12'(16 + gx), 12'(16 + gy), 1'b1);
                check($sformatf("bmp_%0d_%0d", gx, gy), 32'(px(1'b0)),
                      32'(row[7 - gx] ? PX_WHITE : PX_BG));
            end
        end

        // latency: first lit response after exactly 4 clk
        apply_px(12'd0, 12'd0, 1'b1);
        h = 12'd18; v = 12'd17;
        tick(3);
        check("lat3", 32'(px(1'b0)), 32'(PX_OUT));
        tick(1);
        check("lat4", 32'(px(1'b0)), 32'(PX_WHITE));

        // scroll: 'B' green at row 1 comes to the top, row 0 wraps to bottom
        wr(1'b0, 8'd32, 12'h242);
        scroll = 3'd1;
        apply_px(12'd18, 12'd17, 1'b1);
        check("scroll_b_gx2", 32'(px(1'b0)), 32'(PX_GREEN));
        apply_px(12'd17, 12'd17, 1'b1);
        check("scroll_b_gx1", 32'(px(1'b0)), 32'(PX_GREEN));
        apply_px(12'd18, 12'd129, 1'b1);
        check("scroll_wrap_a", 32'(px(1'b0)), 32'(PX_WHITE));
        apply_px(12'd17, 12'd129, 1'b1);
        check("scroll_wrap_a_gx1", 32'(px(1'b0)), 32'(PX_BG));
        scroll = 3'd0;

        // blink: red blink 'A' at cell 0, steady blue 'A' at cell 1
        wr(1'b0, 8'd0, 12'hC41);
        wr(1'b0, 8'd1, 12'h141);
        apply_px(12'd18, 12'd17, 1'b1);
        check("blink_cnt0", 32'(px(1'b0)), 32'(PX_RED));
        frames(31);
        apply_px(12'd18, 12'd17, 1'b1);
        check("blink_cnt31", 32'(px(1'b0)), 32'(PX_RED));
        frames(1);
        apply_px(12'd18, 12'd17, 1'b1);
        check("blink_cnt32", 32'(px(1'b0)), 32'(PX_BG));
        apply_px(12'd26, 12'd17, 1'b1);
        check("steady_cnt32", 32'(px(1'b0)), 32'(PX_BLUE));
        frames(31);
        apply_px(12'd18, 12'd17, 1'b1);
        check("blink_cnt63", 32'(px(1'b0)), 32'(PX_BG));
        frames(1);
        apply_px(12'd18, 12'd17, 1'b1);
        check("blink_wrap", 32'(px(1'b0)), 32'(PX_RED));

        // clear with same-cycle write, then writes and clears during the sweep
        bus0.i_clear = 1'b1; bus0.i_wr = 1'b1; bus0.i_wr_addr = 8'd2; bus0.i_wr_data = 12'h741;
        tick();
        bus0.i_wr_addr = 8'd0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus0.o_busy === 1'b1) cnt++;
            tick();
        end
        bus0.i_clear = 1'b0; bus0.i_wr = 1'b0;
        begin
            int rest;
            count_busy(rest);
            check("busy_len_clear", cnt + rest, 32'd256);
        end
        apply_px(12'd18, 12'd17, 1'b1);
        check("clr_cell0", 32'(px(1'b0)), 32'(PX_BG));
        apply_px(12'd26, 12'd17, 1'b1);
        check("clr_cell1", 32'(px(1'b0)), 32'(PX_BG));
        apply_px(12'd34, 12'd17, 1'b1);
        check("clr_cell2_dropped", 32'(px(1'b0)), 32'(PX_BG));
        apply_px(12'd18, 12'd33, 1'b1);
        check("clr_cell32", 32'(px(1'b0)), 32'(PX_BG));

        // reset mid-clear restarts a full sweep
        bus0.i_clear = 1'b1;
        tick();
        bus0.i_clear = 1'b0;
        tick(100);
        reset = 1'b1;
        h = 12'd18; v = 12'd17; en = 1'b1;
        tick();
        check("rst_mid_px", 32'(px(1'b0)), 32'(PX_OUT));
        reset = 1'b0;
        count_busy(cnt);
        check("busy_len_rst_mid", cnt, 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
